mv_operand_loader: RTL and testbench

//   Upstream feeder for the 10x10 matrix-vector MAC stage. Accepts a serial

---
 rtl/mv_operand_loader.sv | 109 ++++++++++
 tb/tb_mv_operand_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mv_operand_loader.sv
`default_nettype none
// ============================================================================
// mv_operand_loader : serial byte stream -> flattened A/B operand frame
//                     for the NxN matrix-vector MAC stage
// Rev 1.0 : initial release
// ============================================================================
module mv_operand_loader #(
    parameter int N  = 10,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
    input  logic            s_last,
    input  logic            reuse_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] a_flat,
    output logic [N*DW-1:0] b_flat,
    output logic [15:0]     frame_cnt,
    output logic            err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        LOAD_B = 2'd0,
        LOAD_A = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic          in_xfer;
    logic          out_xfer;
    logic          at_last;

    // s_ready is gated by reset so nothing is offered while reset is high
    assign s_ready   = !reset && ((state == LOAD_B) || (state == LOAD_A));
    assign out_valid = (state == HOLD);
    assign in_xfer   = s_valid && s_ready;
    assign out_xfer  = out_valid && out_ready;
    assign at_last   = (idx == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD_B;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            LOAD_B, LOAD_A: begin
                if (in_xfer) begin
                    if (at_last) begin
                        idx_nx   = '0;
                        state_nx = (state == LOAD_B) ? LOAD_A : HOLD;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = reuse_b ? LOAD_A : LOAD_B;
                end
            end
            default: begin
                state_nx = LOAD_B;
                idx_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_flat    <= '0;
            b_flat    <= '0;
            frame_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (in_xfer) begin
                if (state == LOAD_B) begin
                    b_flat[idx*DW +: DW] <= s_data;
                end else begin
                    a_flat[idx*DW +: DW] <= s_data;
                end
                // s_last must coincide exactly with the final element of a phase
                if (s_last != at_last) begin
                    err <= 1'b1;
                end
            end
            if (out_xfer) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mv_operand_loader.sv
`default_nettype none
// ============================================================================
// tb_mv_operand_loader : directed self-checking bench for mv_operand_loader
// Rev 1.0 : initial release
// ============================================================================
module tb_mv_operand_loader;

    localparam int N  = 10;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            s_valid;
    logic            s_ready;
    logic [DW-1:0]   s_data;
    logic            s_last;
    logic            reuse_b;
    logic            out_valid;
    logic            out_ready;
    logic [N*DW-1:0] a_flat;
    logic [N*DW-1:0] b_flat;
    logic [15:0]     frame_cnt;
    logic            err;

    int tests_run = 0;
    int tests_failed = 0;

    mv_operand_loader #(.N(N), .DW(DW)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .reuse_b(reuse_b),
        .out_valid(out_valid), .out_ready(out_ready), .a_flat(a_flat),
        .b_flat(b_flat), .frame_cnt(frame_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] seq(input int start);
        logic [N*DW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(start + k);
        return v;
    endfunction

    // Called and returns at a negedge; one element transfers at the posedge in between.
    task automatic send(input int d, input logic l);
        int guard;
        s_valid = 1'b1;
        s_data  = DW'(d);
        s_last  = l;
        guard   = 0;
        while (!s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) check("send_ready", {79'd0, s_ready}, 80'd1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_phase(input int start, input int err_pos, input bit gap);
        for (int k = 0; k < N; k++) begin
            send(start + k, (k == N-1) || (k == err_pos));
            if (gap && k != N-1) begin
                check("gap_no_valid", {79'd0, out_valid}, 80'd0);
                @(negedge clk);
            end
        end
    endtask

    task automatic accept(input logic rb);
        reuse_b   = rb;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        reuse_b   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        reuse_b = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_ready",   {79'd0, s_ready},   80'd0);
        check("rst_out_valid", {79'd0, out_valid}, 80'd0);
        check("rst_a_flat",    a_flat,             80'd0);
        check("rst_b_flat",    b_flat,             80'd0);
        check("rst_frame_cnt", {64'd0, frame_cnt}, 80'd0);
        check("rst_err",       {79'd0, err},       80'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: basic frame
        send_phase(1, -1, 0);
        for (int k = 0; k < N-1; k++) send(11 + k, 1'b0);
        check("t1_valid_before_last", {79'd0, out_valid}, 80'd0);
        send(20, 1'b1);
        check("t1_out_valid", {79'd0, out_valid}, 80'd1);
        check("t1_b_flat",    b_flat, seq(1));
        check("t1_a_flat",    a_flat, seq(11));
        check("t1_b_hi",      {72'd0, b_flat[79:72]}, 80'd10);
        check("t1_a_hi",      {72'd0, a_flat[79:72]}, 80'd20);
        accept(1'b0);
        check("t1_frame_cnt", {64'd0, frame_cnt}, 80'd1);
        check("t1_valid_drop", {79'd0, out_valid}, 80'd0);
        check("t1_err",       {79'd0, err}, 80'd0);

        // 2: backpressure in HOLD with s_valid held high
        send_phase(31, -1, 0);
        send_phase(41, -1, 0);
        s_valid = 1'b1; s_data = 8'hEE; s_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t2_s_ready", {79'd0, s_ready}, 80'd0);
            check("t2_a_hold",  a_flat, seq(41));
            check("t2_b_hold",  b_flat, seq(31));
            check("t2_valid",   {79'd0, out_valid}, 80'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; out_ready = 1'b0;
        check("t2_s_ready_after", {79'd0, s_ready}, 80'd1);
        check("t2_frame_cnt", {64'd0, frame_cnt}, 80'd2);
        check("t2_a_after",   a_flat, seq(41));
        check("t2_err",       {79'd0, err}, 80'd0);

        // 3: reuse_b keeps B, only A is streamed
        send_phase(1, -1, 0);
        send_phase(11, -1, 0);
        accept(1'b1);
        for (int k = 0; k < N-1; k++) send(21 + k, 1'b0);
        check("t3_valid_before_last", {79'd0, out_valid}, 80'd0);
        send(30, 1'b1);
        check("t3_out_valid", {79'd0, out_valid}, 80'd1);
        check("t3_b_flat",    b_flat, seq(1));
        check("t3_a_flat",    a_flat, seq(21));
        check("t3_a_lo",      {72'd0, a_flat[7:0]}, 80'd21);
        accept(1'b0);
        check("t3_frame_cnt", {64'd0, frame_cnt}, 80'd4);

        // 4: early s_last on B element 4 sets sticky err, phase continues
        for (int k = 0; k < N; k++) begin
            send(51 + k, (k == 3) || (k == N-1));
            if (k == 3) check("t4_err_set", {79'd0, err}, 80'd1);
        end
        check("t4_still_loading", {79'd0, s_ready}, 80'd1);
        send_phase(61, -1, 0);
        check("t4_out_valid", {79'd0, out_valid}, 80'd1);
        check("t4_b_flat",    b_flat, seq(51));
        accept(1'b0);
        send_phase(1, -1, 0);
        send_phase(11, -1, 0);
        accept(1'b0);
        check("t4_err_sticky", {79'd0, err}, 80'd1);
        check("t4_frame_cnt",  {64'd0, frame_cnt}, 80'd6);

        // 5: gapped input, s_valid toggling every cycle
        send_phase(1, -1, 1);
        @(negedge clk);
        check("t5_gap_phase", {79'd0, out_valid}, 80'd0);
        send_phase(11, -1, 1);
        check("t5_out_valid", {79'd0, out_valid}, 80'd1);
        check("t5_b_flat",    b_flat, seq(1));
        check("t5_a_flat",    a_flat, seq(11));
        accept(1'b0);

        // 6: asynchronous reset mid-LOAD_A at idx=5, between edges
        send_phase(71, -1, 0);
        for (int k = 0; k < 5; k++) send(81 + k, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("t6_out_valid", {79'd0, out_valid}, 80'd0);
        check("t6_a_flat",    a_flat, 80'd0);
        check("t6_b_flat",    b_flat, 80'd0);
        check("t6_frame_cnt", {64'd0, frame_cnt}, 80'd0);
        check("t6_err",       {79'd0, err}, 80'd0);
        check("t6_s_ready",   {79'd0, s_ready}, 80'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_phase(91, -1, 0);
        send_phase(101, -1, 0);
        check("t6_fresh_valid", {79'd0, out_valid}, 80'd1);
        check("t6_fresh_b",     b_flat, seq(91));
        check("t6_fresh_a",     a_flat, seq(101));
        accept(1'b0);
        check("t6_fresh_cnt",   {64'd0, frame_cnt}, 80'd1);
        check("t6_fresh_err",   {79'd0, err}, 80'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
